// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the AES core scheduler.
package aes_sched_pkg;

  localparam int unsigned BLOCK_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESPOND
  } state_t;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = encrypt, bit 1 = decrypt, one-hot grant.
module aes_rr_arb2
  import aes_sched_pkg::*;
(
  input  logic [1:0] req,
  input  mode_t      last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // On a tie the side that did not win last time gets the core.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last_grant == MODE_DEC) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES-128 round core between encrypt and decrypt requesters.
// Define AES_SCHED_WDOG_EN to add a BUSY watchdog and the sticky wdog_err flag.
module aes_core_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned BLOCK_W = BLOCK_W_DEF
`ifdef AES_SCHED_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 32
`endif
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               enc_req,
  input  logic [BLOCK_W-1:0] enc_key,
  input  logic [BLOCK_W-1:0] enc_data,
  output logic               enc_ack,
  output logic [BLOCK_W-1:0] enc_result,
  input  logic               dec_req,
  input  logic [BLOCK_W-1:0] dec_key,
  input  logic [BLOCK_W-1:0] dec_data,
  output logic               dec_ack,
  output logic [BLOCK_W-1:0] dec_result,
  output logic [BLOCK_W-1:0] core_key,
  output logic [BLOCK_W-1:0] core_data,
  output logic               core_mode,
  output logic               core_start,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               busy
`ifdef AES_SCHED_WDOG_EN
  ,
  output logic               wdog_err
`endif
);

  state_t     state;
  mode_t      last_grant;
  logic [1:0] gnt;
  logic       wdog_hit;

  aes_rr_arb2 u_arb (
    .req       ({dec_req, enc_req}),
    .last_grant(last_grant),
    .en        (state == IDLE),
    .gnt       (gnt)
  );

`ifdef AES_SCHED_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt;

  // Fires on the last permitted BUSY cycle so BUSY lasts exactly WDOG_CYCLES cycles.
  assign wdog_hit = (state == BUSY) && !core_done && (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wdog_cnt <= '0;
      end else if (state == BUSY && !core_done) begin
        wdog_cnt <= wdog_cnt + CNT_W'(1);
      end
      if (wdog_hit) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Scheduler FSM with registered core handshake and requester acks.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      last_grant <= MODE_DEC;
      core_key   <= '0;
      core_data  <= '0;
      core_mode  <= 1'b0;
      core_start <= 1'b0;
      enc_ack    <= 1'b0;
      dec_ack    <= 1'b0;
      enc_result <= '0;
      dec_result <= '0;
      busy       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      enc_ack    <= 1'b0;
      dec_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            core_key   <= gnt[1] ? dec_key : enc_key;
            core_data  <= gnt[1] ? dec_data : enc_data;
            core_mode  <= gnt[1];
            last_grant <= gnt[1] ? MODE_DEC : MODE_ENC;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= BUSY;
        end
        BUSY: begin
          // A watchdog abort returns an all-zero result through the normal ack path.
          if (core_done || wdog_hit) begin
            if (core_mode == MODE_DEC) begin
              dec_result <= core_done ? core_result : '0;
              dec_ack    <= 1'b1;
            end else begin
              enc_result <= core_done ? core_result : '0;
              enc_ack    <= 1'b1;
            end
            state <= RESPOND;
          end
        end
        RESPOND: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed self-checking bench for aes_core_scheduler.
module tb_aes_core_scheduler;

  localparam int unsigned W = 128;
  localparam logic [W-1:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] D1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] KE  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [W-1:0] DE  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [W-1:0] KD  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [W-1:0] DD  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         enc_req, dec_req, core_done;
  logic [W-1:0] enc_key, enc_data, dec_key, dec_data, core_result;
  logic         enc_ack, dec_ack, core_mode, core_start, busy;
  logic [W-1:0] enc_result, dec_result, core_key, core_data;
`ifdef AES_SCHED_WDOG_EN
  logic         wdog_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  aes_core_scheduler dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .enc_req    (enc_req),
    .enc_key    (enc_key),
    .enc_data   (enc_data),
    .enc_ack    (enc_ack),
    .enc_result (enc_result),
    .dec_req    (dec_req),
    .dec_key    (dec_key),
    .dec_data   (dec_data),
    .dec_ack    (dec_ack),
    .dec_result (dec_result),
    .core_key   (core_key),
    .core_data  (core_data),
    .core_mode  (core_mode),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result),
    .busy       (busy)
`ifdef AES_SCHED_WDOG_EN
    ,
    .wdog_err   (wdog_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    enc_req = 1'b0; dec_req = 1'b0; core_done = 1'b0;
    enc_key = '0; enc_data = '0; dec_key = '0; dec_data = '0; core_result = '0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    enc_req = 1'b0; dec_req = 1'b0; core_done = 1'b0;
    enc_key = '0; enc_data = '0; dec_key = '0; dec_data = '0; core_result = '0;
    #1;
    vectors++;
    if ({busy, core_start, enc_ack, dec_ack, core_mode} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, core_start, enc_ack, dec_ack, core_mode});
    end
    vectors++;
    if ((core_key | core_data | enc_result | dec_result) !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", core_key | core_data | enc_result | dec_result);
    end
    tick();
    n_rst = 1'b1;
    tick();
    vectors++;
    if ({busy, core_start} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: busy/start got %b required 00", {busy, core_start});
    end
  endtask

  task automatic test_single();
    logic bad;
    do_reset();
    enc_key = K1; enc_data = D1; enc_req = 1'b1;
    tick();
    vectors++;
    if ({core_start, core_mode, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL t1_start: start/mode/busy got %b required 101", {core_start, core_mode, busy});
    end
    vectors++;
    if (core_key !== K1 || core_data !== D1) begin
      miscompares++;
      $display("FAIL t1_latch: key %h data %h required %h %h", core_key, core_data, K1, D1);
    end
    bad = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (core_start !== 1'b0 || enc_ack !== 1'b0 || dec_ack !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL t1_quiet: start/ack seen during BUSY, required none");
    end
    core_done = 1'b1; core_result = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    tick();
    core_done = 1'b0; enc_req = 1'b0;
    vectors++;
    if ({enc_ack, dec_ack} !== 2'b10 || enc_result !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      miscompares++;
      $display("FAIL t1_ack: acks %b result %h required 10 69c4e0d86a7b0430d8cdb78070b4c55a",
               {enc_ack, dec_ack}, enc_result);
    end
    tick();
    vectors++;
    if (enc_ack !== 1'b0 || busy !== 1'b0 || core_key !== K1 ||
        enc_result !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      miscompares++;
      $display("FAIL t1_hold: ack %b busy %b key %h result %h", enc_ack, busy, core_key, enc_result);
    end
  endtask

  task automatic test_alternate();
    logic ok;
    logic exp_dec;
    logic [W-1:0] res;
    do_reset();
    enc_key = KE; enc_data = DE; dec_key = KD; dec_data = DD;
    enc_req = 1'b1; dec_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_dec = (g % 2) == 1;
      res = 128'h0a0 + W'(g);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (core_start === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      vectors++;
      if (!ok || core_mode !== exp_dec || core_key !== (exp_dec ? KD : KE)) begin
        miscompares++;
        $display("FAIL t2_grant%0d: start %b mode %b key %h required mode %b", g, ok, core_mode,
                 core_key, exp_dec);
      end
      tick();
      tick();
      core_done = 1'b1; core_result = res;
      tick();
      core_done = 1'b0;
      vectors++;
      if ({enc_ack, dec_ack} !== (exp_dec ? 2'b01 : 2'b10) ||
          (exp_dec ? dec_result : enc_result) !== res) begin
        miscompares++;
        $display("FAIL t2_ack%0d: acks %b enc %h dec %h required result %h", g, {enc_ack, dec_ack},
                 enc_result, dec_result, res);
      end
    end
    enc_req = 1'b0; dec_req = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    logic ok;
    do_reset();
    dec_key = KD; dec_data = DD; dec_req = 1'b1;
    tick();
    vectors++;
    if (core_start !== 1'b1 || core_mode !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_start: start %b mode %b required 1 1", core_start, core_mode);
    end
    tick();
    dec_req = 1'b0;
    tick();
    tick();
    core_done = 1'b1; core_result = 128'h00000000deadbeef00000000cafef00d;
    tick();
    core_done = 1'b0;
    vectors++;
    if ({enc_ack, dec_ack} !== 2'b01 || dec_result !== 128'h00000000deadbeef00000000cafef00d) begin
      miscompares++;
      $display("FAIL t3_ack: acks %b result %h required 01 00000000deadbeef00000000cafef00d",
               {enc_ack, dec_ack}, dec_result);
    end
    tick();
    tick();
    vectors++;
    if ({busy, dec_ack, core_start} !== 3'b000) begin
      miscompares++;
      $display("FAIL t3_idle: busy/ack/start got %b required 000", {busy, dec_ack, core_start});
    end
    enc_key = KE; enc_data = DE; enc_req = 1'b1; dec_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (core_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok || core_mode !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_next: start %b mode %b required 1 0", ok, core_mode);
    end
    tick();
    core_done = 1'b1; core_result = 128'h1;
    tick();
    core_done = 1'b0; enc_req = 1'b0; dec_req = 1'b0;
    tick();
  endtask

  task automatic test_early_done();
    logic bad;
    do_reset();
    enc_key = K1; enc_data = D1; enc_req = 1'b1;
    tick();
    core_done = 1'b1; core_result = 128'hbad;
    tick();
    core_done = 1'b0;
    bad = (enc_ack !== 1'b0);
    for (int c = 3; c <= 6; c++) begin
      tick();
      if (enc_ack !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_ignore: early ack %b busy %b required 0 1", bad, busy);
    end
    core_done = 1'b1; core_result = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    tick();
    core_done = 1'b0; enc_req = 1'b0;
    vectors++;
    if (enc_ack !== 1'b1 || enc_result !== 128'h3ad77bb40d7a3660a89ecaf32466ef97) begin
      miscompares++;
      $display("FAIL t4_ack: ack %b result %h required 1 3ad77bb40d7a3660a89ecaf32466ef97",
               enc_ack, enc_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic ok;
    do_reset();
    enc_key = KE; enc_data = DE; dec_key = KD; dec_data = DD;
    enc_req = 1'b1; dec_req = 1'b1;
    tick();
    vectors++;
    if (core_start !== 1'b1 || core_mode !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_first: start %b mode %b required 1 0", core_start, core_mode);
    end
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({busy, core_start, enc_ack, dec_ack, core_mode} !== 5'b0 || core_key !== '0) begin
      miscompares++;
      $display("FAIL t5_async: ctrl %b key %h required 00000 0",
               {busy, core_start, enc_ack, dec_ack, core_mode}, core_key);
    end
    tick();
    n_rst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (core_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok || core_mode !== 1'b0 || core_key !== KE) begin
      miscompares++;
      $display("FAIL t5_regrant: start %b mode %b key %h required 1 0 %h", ok, core_mode, core_key, KE);
    end
    tick();
    core_done = 1'b1; core_result = 128'h55;
    tick();
    core_done = 1'b0; enc_req = 1'b0; dec_req = 1'b0;
    vectors++;
    if ({enc_ack, dec_ack} !== 2'b10 || enc_result !== 128'h55) begin
      miscompares++;
      $display("FAIL t5_ack: acks %b result %h required 10 55", {enc_ack, dec_ack}, enc_result);
    end
    tick();
  endtask

`ifdef AES_SCHED_WDOG_EN
  task automatic test_wdog();
    int n;
    do_reset();
    enc_key = K1; enc_data = D1; enc_req = 1'b1;
    tick();
    tick();
    core_done = 1'b1; core_result = 128'h77;
    tick();
    core_done = 1'b0; enc_req = 1'b0;
    tick();
    enc_req = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (enc_ack === 1'b1) break;
    end
    enc_req = 1'b0;
    vectors++;
    if (n != 33 || enc_result !== '0 || wdog_err !== 1'b1) begin
      miscompares++;
      $display("FAIL t6_abort: ack after %0d cycles result %h err %b required 33 0 1", n, enc_result,
               wdog_err);
    end
    tick();
    tick();
    vectors++;
    if (wdog_err !== 1'b1) begin
      miscompares++;
      $display("FAIL t6_sticky: err %b required 1", wdog_err);
    end
    do_reset();
    vectors++;
    if (wdog_err !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_clear: err %b required 0", wdog_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_drop();
    test_early_done();
    test_reset_mid();
`ifdef AES_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
